pipe_stage_reg: RTL

//   Parametrised elastic pipeline register carrying {instr, pc} between any two CPU stages
//   (IF/ID, ID/EX, ...). Replaces fixed enable-only stage registers with a valid/ready

---
 rtl/pipe_stage_reg.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// Elastic {instr, pc} pipeline register with valid/ready handshake,
// 2-entry skid buffer (registered in_ready) and synchronous bubble flush.
// Ports: clk, reset (async, active-high), flush,
//   in_valid/in_ready/in_instr/in_pc (upstream),
//   out_valid/out_ready/out_instr/out_pc (downstream),
//   stall_cnt (stalled-cycle counter).
// Optional feature macro PIPE_STALL_CNT_EN enables stall_cnt;
// without it stall_cnt is tied to zero.
module pipe_stage_reg #(
  parameter int            IW        = 32,
  parameter int            AW        = 32,
  parameter logic [IW-1:0] NOP_INSTR = '0,
  parameter logic [AW-1:0] RESET_PC  = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [IW-1:0] in_instr,
  input  logic [AW-1:0] in_pc,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [IW-1:0] out_instr,
  output logic [AW-1:0] out_pc,
  output logic [31:0]   stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          rdy_q, rdy_d;
  logic [IW-1:0] m_instr_q, m_instr_d;
  logic [AW-1:0] m_pc_q, m_pc_d;
  logic [IW-1:0] s_instr_q, s_instr_d;
  logic [AW-1:0] s_pc_q, s_pc_d;
  logic          accept, consume;

  assign accept  = in_valid && rdy_q;
  assign consume = (state_q != EMPTY) && out_ready;

  always_comb begin
    state_d   = state_q;
    m_instr_d = m_instr_q;
    m_pc_d    = m_pc_q;
    s_instr_d = s_instr_q;
    s_pc_d    = s_pc_q;
    if (flush) begin
      state_d   = EMPTY;
      m_instr_d = NOP_INSTR;
      m_pc_d    = RESET_PC;
      s_instr_d = NOP_INSTR;
      s_pc_d    = RESET_PC;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d   = FULL;
            m_instr_d = in_instr;
            m_pc_d    = in_pc;
          end
        end
        FULL: begin
          if (accept && consume) begin
            m_instr_d = in_instr;
            m_pc_d    = in_pc;
          end else if (accept) begin
            state_d   = SKID;
            s_instr_d = in_instr;
            s_pc_d    = in_pc;
          end else if (consume) begin
            state_d   = EMPTY;
            m_instr_d = NOP_INSTR;
            m_pc_d    = RESET_PC;
          end
        end
        SKID: begin
          // in_ready is low here, so no accept can coincide.
          if (consume) begin
            state_d   = FULL;
            m_instr_d = s_instr_q;
            m_pc_d    = s_pc_q;
            s_instr_d = NOP_INSTR;
            s_pc_d    = RESET_PC;
          end
        end
        default: begin
          state_d   = EMPTY;
          m_instr_d = NOP_INSTR;
          m_pc_d    = RESET_PC;
          s_instr_d = NOP_INSTR;
          s_pc_d    = RESET_PC;
        end
      endcase
    end
    // Ready is a flop computed from the next state only.
    rdy_d = (state_d != SKID);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= EMPTY;
      rdy_q     <= 1'b1;
      m_instr_q <= NOP_INSTR;
      m_pc_q    <= RESET_PC;
      s_instr_q <= NOP_INSTR;
      s_pc_q    <= RESET_PC;
    end else begin
      state_q   <= state_d;
      rdy_q     <= rdy_d;
      m_instr_q <= m_instr_d;
      m_pc_q    <= m_pc_d;
      s_instr_q <= s_instr_d;
      s_pc_q    <= s_pc_d;
    end
  end

  // M is bubbled whenever the stage is empty, so it drives out_* directly.
  assign in_ready  = rdy_q;
  assign out_valid = (state_q != EMPTY);
  assign out_instr = m_instr_q;
  assign out_pc    = m_pc_q;

`ifdef PIPE_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (out_valid && !out_ready && (stall_q != 32'hFFFF_FFFF))
      stall_d = stall_q + 32'd1;
  end

  // Flush does not clear the counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) stall_q <= 32'd0;
    else       stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 32'd0;
`endif

endmodule
